fir_tap_sequencer: RTL and testbench

Time-multiplexed FIR control stage that sits directly upstream of the single-MAC `alu` stage. It accepts input samples over a valid/ready handshake and stores the last NTAPS samples in a circular buffer. It also holds a loadable coefficient bank and sequences one tap per cycle into the MAC (x, b, running sum). It captures the finished 39-bit sum and presents it downstream with valid/ready.

---
 rtl/fir_pkg.sv | 24 ++
 rtl/fir_sample_ring.sv | 39 +++
 rtl/fir_tap_sequencer.sv | 100 ++++++++++
 tb/tb_fir_tap_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR tap sequencer.
// Holds width defaults, FSM state encoding and ring-pointer arithmetic.
package fir_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 2 * DW_DEF + 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    CAP  = 2'd2,
    OUT  = 2'd3
  } state_t;

  // (p - k) mod n for p, k < n, without a divider
  function automatic int unsigned ring_dec(
    input int unsigned p,
    input int unsigned k,
    input int unsigned n
  );
    return (p >= k) ? p - k : p + n - k;
  endfunction

endpackage

// File: rtl/fir_sample_ring.sv
// Circular sample history: write port, wrapping write pointer, newest index.
// Ports: clk, rstn, we/wdata (write), k (tap age), rdata = buf[newest-k], newest.
module fir_sample_ring
  import fir_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int DW    = DW_DEF,
  localparam int IW   = $clog2(NTAPS)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] k,
  output logic [DW-1:0] rdata,
  output logic [IW-1:0] newest
);

  logic [DW-1:0] mem [NTAPS];
  logic [IW-1:0] wr_ptr;
  logic [IW-1:0] rd_idx;

  assign rd_idx = IW'(ring_dec(32'(newest), 32'(k), NTAPS));
  assign rdata  = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      newest <= '0;
      for (int i = 0; i < NTAPS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_ptr] <= wdata;
      newest      <= wr_ptr;
      // explicit wrap so NTAPS need not be a power of two
      wr_ptr <= (wr_ptr == IW'(NTAPS - 1)) ? '0 : wr_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR control stage feeding a single registered MAC one tap per cycle.
// Ports: coef_* bank write, s_* sample in, mac_* MAC link, m_* result out, busy.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  localparam int IW   = $clog2(NTAPS)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          coef_we,
  input  logic [IW-1:0] coef_addr,
  input  logic [DW-1:0] coef_data,
  output logic          busy,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic [DW-1:0] mac_x,
  output logic [DW-1:0] mac_b,
  output logic [AW-1:0] mac_sum_in,
  input  logic [AW-1:0] mac_sum_out,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW-1:0] m_data
);

  state_t        state;
  state_t        state_n;
  logic [IW-1:0] k;
  logic [DW-1:0] h [NTAPS];
  logic [AW-1:0] data_q;
  logic [DW-1:0] rdata;
  logic [IW-1:0] newest;
  logic          accept;
  logic          last;
  logic          in_mac;

  fir_sample_ring #(
    .NTAPS (NTAPS),
    .DW    (DW)
  ) u_ring (
    .clk    (clk),
    .rstn   (rstn),
    .we     (accept),
    .wdata  (s_data),
    .k      (k),
    .rdata  (rdata),
    .newest (newest)
  );

  assign last = (k == IW'(NTAPS - 1));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (s_valid) state_n = MAC;
      MAC:  if (last) state_n = CAP;
      CAP:  state_n = OUT;
      OUT:  if (m_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // outputs are gated by rstn so they read zero during the reset cycle
  always_comb begin
    s_ready    = rstn && (state == IDLE);
    busy       = rstn && (state != IDLE);
    m_valid    = rstn && (state == OUT);
    m_data     = rstn ? data_q : '0;
    accept     = s_ready && s_valid;
    in_mac     = rstn && (state == MAC);
    mac_x      = '0;
    mac_b      = '0;
    mac_sum_in = '0;
    if (in_mac) begin
      mac_x = rdata;
      mac_b = h[k];
      if (k != '0) mac_sum_in = mac_sum_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      k      <= '0;
      data_q <= '0;
      for (int i = 0; i < NTAPS; i++) h[i] <= '0;
    end else begin
      state <= state_n;
      if (accept) k <= '0;
      else if (state == MAC && !last) k <= k + 1'b1;
      if (state == CAP) data_q <= mac_sum_out;
      if (coef_we && state == IDLE && 32'(coef_addr) < NTAPS)
        h[coef_addr] <= coef_data;
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer with a behavioural MAC.
// Reference: history array times coefficient array, summed in 64 bits.
module tb_fir_tap_sequencer;

  localparam int NT = 8;
  localparam int DW = 16;
  localparam int AW = 39;
  localparam int IW = $clog2(NT);

  logic          clk = 1'b0;
  logic          rstn;
  logic          coef_we;
  logic [IW-1:0] coef_addr;
  logic [DW-1:0] coef_data;
  logic          busy;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic [DW-1:0] mac_x;
  logic [DW-1:0] mac_b;
  logic [AW-1:0] mac_sum_in;
  logic [AW-1:0] mac_sum_out;
  logic          m_valid;
  logic          m_ready;
  logic [AW-1:0] m_data;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] hh [NT];
  logic [DW-1:0] hx [NT];

  always #5 clk = ~clk;

  fir_tap_sequencer #(.NTAPS(NT)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .busy        (busy),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .mac_x       (mac_x),
    .mac_b       (mac_b),
    .mac_sum_in  (mac_sum_in),
    .mac_sum_out (mac_sum_out),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data)
  );

  // downstream MAC: registered sum_in + x*b, one cycle latency
  always_ff @(posedge clk) begin
    if (!rstn) mac_sum_out <= '0;
    else mac_sum_out <= mac_sum_in + AW'(mac_x) * AW'(mac_b);
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] model_y();
    longint unsigned s = 0;
    for (int i = 0; i < NT; i++) s += 64'(hh[i]) * 64'(hx[i]);
    return AW'(s);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NT; i++) begin
      hh[i] = '0;
      hx[i] = '0;
    end
  endtask

  task automatic model_push(input logic [DW-1:0] x);
    for (int i = NT - 1; i > 0; i--) hx[i] = hx[i-1];
    hx[0] = x;
  endtask

  task automatic wait_ready(input string tag);
    logic ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  task automatic wc(input int a, input logic [DW-1:0] d);
    wait_ready("coef_ready");
    coef_we   = 1'b1;
    coef_addr = IW'(a);
    coef_data = d;
    hh[a]     = d;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  // mode 0: plain; 1: coef write same cycle as accept; 2: write in MAC
  task automatic send(input logic [DW-1:0] x, input int hold,
                      input int mode, input int ca,
                      input logic [DW-1:0] cd, input string tag,
                      output logic [AW-1:0] y);
    logic [AW-1:0] exp;
    logic ok;
    logic stable;
    wait_ready("s_ready_wait");
    s_valid = 1'b1;
    s_data  = x;
    if (mode != 0) begin
      coef_we   = 1'b1;
      coef_addr = IW'(ca);
      coef_data = cd;
      if (mode == 1) hh[ca] = cd;
      if (mode == 2) coef_we = 1'b0;
    end
    model_push(x);
    exp = model_y();
    @(negedge clk);
    s_valid = 1'b0;
    coef_we = (mode == 2);
    m_ready = 1'b0;
    check("busy_mac", 64'(busy), 64'd1);
    @(negedge clk);
    coef_we = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("valid_wait", 64'(ok), 64'd1);
    check(tag, 64'(m_data), 64'(exp));
    y = m_data;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (m_data !== exp || !m_valid || s_ready || !busy) stable = 1'b0;
    end
    check("hold_stable", 64'(stable), 64'd1);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("post_hs_valid", 64'(m_valid), 64'd0);
    check("post_hs_ready", 64'(s_ready), 64'd1);
  endtask

  initial begin
    logic [AW-1:0] y;
    logic quiet;
    rstn      = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    s_valid   = 1'b0;
    s_data    = '0;
    m_ready   = 1'b0;
    model_clear();

    // reset state
    repeat (3) @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_mac", 64'({mac_x, mac_b, mac_sum_in}), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(s_ready), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);

    // impulse response
    for (int i = 0; i < NT; i++) wc(i, DW'(i + 1));
    for (int i = 0; i < NT; i++) begin
      send((i == 0) ? 16'd1 : 16'd0, 0, 0, 0, '0, "impulse", y);
      check("impulse_lit", 64'(y), 64'(i + 1));
    end
    send(16'd0, 0, 0, 0, '0, "impulse_tail", y);
    check("impulse_tail_lit", 64'(y), 64'd0);

    // step with ramp coefficients
    for (int i = 0; i < NT; i++) send(16'd2, 0, 0, 0, '0, "step", y);
    check("step_last_lit", 64'(y), 64'd72);

    // maximum magnitude
    for (int i = 0; i < NT; i++) wc(i, 16'hFFFF);
    for (int i = 0; i < NT; i++) send(16'hFFFF, 0, 0, 0, '0, "max", y);
    check("max_lit", 64'(y), 64'h7_FFF0_0008);

    // backpressure for 20 cycles
    send(16'($urandom), 20, 0, 0, '0, "backpressure", y);

    // write while busy is dropped; write with accept in IDLE is used
    for (int i = 0; i < NT; i++) wc(i, DW'(i + 1));
    send(16'd3, 0, 2, 0, 16'd9, "coef_busy_drop", y);
    send(16'd4, 0, 1, 0, 16'd9, "coef_idle_same", y);
    send(16'd5, 0, 0, 0, '0, "coef_idle_next", y);

    // reset while k == 3
    wait_ready("mid_ready");
    s_valid = 1'b1;
    s_data  = 16'd7;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", 64'(busy), 64'd1);
    check("mid_mac_b", 64'(mac_b), 64'd4);
    rstn = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_mac", 64'({mac_x, mac_b, mac_sum_in}), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    model_clear();
    m_ready = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < NT + 6; i++) begin
      @(negedge clk);
      if (m_valid || !s_ready) quiet = 1'b0;
    end
    m_ready = 1'b0;
    check("mid_rst_quiet", 64'(quiet), 64'd1);
    send(16'd1, 0, 0, 0, '0, "post_rst_impulse", y);
    check("post_rst_lit", 64'(y), 64'd0);

    // randomized traffic
    for (int i = 0; i < NT; i++) wc(i, 16'($urandom));
    for (int n = 0; n < 30; n++) begin
      int m;
      m = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      send(16'($urandom), $urandom_range(0, 3), m,
           $urandom_range(0, NT - 1), 16'($urandom), "random", y);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
